// File: rtl/noc_pkg.sv
// Router-wide constants: port/VC counts, index widths, port names.
// Shared by the VC allocator and its round-robin arbiter.
package noc_pkg;
  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL,
    NORTH,
    SOUTH,
    WEST,
    EAST
  } port_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at/after ptr wins, wrapping.
// Ports: clk, rst (async low), req_i, en_i (advance) -> gnt_o, valid_o.
module rr_arbiter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] widx;
  logic          found;

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    widx  = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found = 1'b1;
        widx  = PW'(j);
      end
    end
  end

  assign valid_o = found;
  assign gnt_o   = found ? (N'(1) << widx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && found) begin
      ptr_d = (int'(widx) == N - 1) ? '0 : widx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vc_allocator.sv
// Downstream VC allocator: one RR arbiter per output port, lowest free VC.
// Ports: request_i/out_port_i in, release_i frees, grant_o/downstream_vc_o/vc_busy_o out.
module vc_allocator
  import noc_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]                release_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]                grant_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]                vc_busy_o
);
  localparam int N = PORT_NUM * VC_NUM;

  logic [PORT_NUM-1:0][VC_NUM-1:0]              grant_q, grant_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc_q, dvc_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              busy_q, busy_d;

  logic [PORT_NUM-1:0][N-1:0]       cand;
  logic [PORT_NUM-1:0][N-1:0]       arb_gnt;
  logic [PORT_NUM-1:0]              arb_valid;
  logic [PORT_NUM-1:0]              free_any;
  logic [PORT_NUM-1:0]              en;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] free_vc;

  // Grant mask: requester only sees its grant a cycle late.
  always_comb begin
    cand = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int u = 0; u < PORT_NUM; u++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          cand[p][u*VC_NUM+v] = request_i[u][v] & ~grant_q[u][v]
                              & (out_port_i[u][v] == PORT_SIZE'(p));
        end
      end
    end
  end

  always_comb begin
    free_any = '0;
    free_vc  = '0;
    en       = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      free_any[p] = ~&busy_q[p];
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        if (!busy_q[p][v]) free_vc[p] = VC_SIZE'(v);
      end
      en[p] = arb_valid[p] & free_any[p];
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_arb
    rr_arbiter #(.N(N)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   (cand[p]),
      .en_i    (free_any[p]),
      .gnt_o   (arb_gnt[p]),
      .valid_o (arb_valid[p])
    );
  end

  always_comb begin
    grant_d = '0;
    dvc_d   = dvc_q;
    busy_d  = busy_q & ~release_i;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (en[p]) begin
        busy_d[p][free_vc[p]] = 1'b1;
        for (int u = 0; u < PORT_NUM; u++) begin
          for (int v = 0; v < VC_NUM; v++) begin
            if (arb_gnt[p][u*VC_NUM+v]) begin
              grant_d[u][v] = 1'b1;
              dvc_d[u][v]   = free_vc[p];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      dvc_q   <= '0;
      busy_q  <= '0;
    end else begin
      grant_q <= grant_d;
      dvc_q   <= dvc_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o         = grant_q;
  assign downstream_vc_o = dvc_q;
  assign vc_busy_o       = busy_q;
endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator with hand-computed expectations.
// Covers reset, latency, stall/release, fairness, parallel ports, async reset.
module tb_vc_allocator;
  import noc_pkg::*;

  logic clk;
  logic rst;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                release_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                grant_o;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   downstream_vc_o;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                vc_busy_o;

  int n_checks = 0;
  int n_errors = 0;

  vc_allocator dut (
    .clk             (clk),
    .rst             (rst),
    .request_i       (request_i),
    .out_port_i      (out_port_i),
    .release_i       (release_i),
    .grant_o         (grant_o),
    .downstream_vc_o (downstream_vc_o),
    .vc_busy_o       (vc_busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    request_i  = '0;
    out_port_i = '0;
    release_i  = '0;
    #2 rst = 1'b0;
    tick();
    #2 rst = 1'b1;
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    request_i  = '0;
    out_port_i = '0;
    release_i  = '0;
    #1;
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_busy", 32'(vc_busy_o), 32'h0);
    check("rst_dvc", 32'(downstream_vc_o), 32'h0);
    do_reset();

    // (1,0) -> port 3: one-cycle grant pulse, VC0
    request_i[1][0]  = 1'b1;
    out_port_i[1][0] = 3'd3;
    tick();
    check("t1_grant", 32'(grant_o), 32'h4);
    check("t1_dvc", 32'(downstream_vc_o[1][0]), 32'h0);
    check("t1_busy3", 32'(vc_busy_o[3]), 32'h1);
    tick();
    check("t1_drop", 32'(grant_o), 32'h0);
    do_reset();

    // r=2,4,6 -> port 0
    request_i[1][0] = 1'b1;
    request_i[2][0] = 1'b1;
    request_i[3][0] = 1'b1;
    tick();
    check("t2_g2", 32'(grant_o), 32'h4);
    check("t2_v2", 32'(downstream_vc_o[1][0]), 32'h0);
    request_i[1][0] = 1'b0;
    tick();
    check("t2_g4", 32'(grant_o), 32'h10);
    check("t2_v4", 32'(downstream_vc_o[2][0]), 32'h1);
    check("t2_busy", 32'(vc_busy_o[0]), 32'h3);
    request_i[2][0] = 1'b0;
    tick();
    tick();
    check("t2_stall", 32'(grant_o), 32'h0);
    check("t2_busy_hold", 32'(vc_busy_o[0]), 32'h3);
    release_i[0][1] = 1'b1;
    tick();
    release_i[0][1] = 1'b0;
    check("t3_busy_clr", 32'(vc_busy_o[0]), 32'h1);
    check("t3_nogrant", 32'(grant_o), 32'h0);
    tick();
    check("t3_g6", 32'(grant_o), 32'h40);
    check("t3_v6", 32'(downstream_vc_o[3][0]), 32'h1);
    check("t3_busy", 32'(vc_busy_o[0]), 32'h3);
    request_i[3][0] = 1'b0;
    // releasing a free VC is harmless
    release_i[1][0] = 1'b1;
    tick();
    release_i[1][0] = 1'b0;
    check("free_rel", 32'(vc_busy_o), 32'h3);
    do_reset();

    // Fairness: r=0 and r=9 -> port 2, release right after each grant
    request_i[0][0]  = 1'b1;
    request_i[4][1]  = 1'b1;
    out_port_i[0][0] = 3'd2;
    out_port_i[4][1] = 3'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) begin
        check("fair_g0", 32'(grant_o), 32'h1);
        check("fair_v0", 32'(downstream_vc_o[0][0]), 32'h0);
        release_i[2] = 2'b01;
      end else begin
        check("fair_g9", 32'(grant_o), 32'h200);
        check("fair_v9", 32'(downstream_vc_o[4][1]), 32'h1);
        release_i[2] = 2'b10;
      end
    end
    do_reset();

    // Two ports in one cycle: r=1 -> 4, r=3 -> 2
    request_i[0][1]  = 1'b1;
    request_i[1][1]  = 1'b1;
    out_port_i[0][1] = 3'd4;
    out_port_i[1][1] = 3'd2;
    tick();
    check("par_grant", 32'(grant_o), 32'ha);
    check("par_v1", 32'(downstream_vc_o[0][1]), 32'h0);
    check("par_v3", 32'(downstream_vc_o[1][1]), 32'h0);
    check("par_busy", 32'(vc_busy_o), 32'h110);
    request_i = '0;

    // Out-of-range port is ignored
    request_i[2][0]  = 1'b1;
    out_port_i[2][0] = 3'd5;
    tick();
    tick();
    check("oob_grant", 32'(grant_o), 32'h0);
    check("oob_busy", 32'(vc_busy_o), 32'h110);
    request_i = '0;

    // Async reset mid-cycle
    #3 rst = 1'b0;
    #1;
    check("arst_busy", 32'(vc_busy_o), 32'h0);
    check("arst_grant", 32'(grant_o), 32'h0);
    check("arst_dvc", 32'(downstream_vc_o), 32'h0);
    #2 rst = 1'b1;
    tick();
    request_i[2][1]  = 1'b1;
    out_port_i[2][1] = 3'd1;
    tick();
    check("post_grant", 32'(grant_o), 32'h20);
    check("post_vc", 32'(downstream_vc_o[2][1]), 32'h0);
    check("post_busy", 32'(vc_busy_o[1]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
